apb_master_arbiter: RTL and testbench
=====================================

Name: apb_master_arbiter

Overview:
- Shares one APB slave port, such as the team's 32x32 APB memory slave, between NREQ local requesters.
- Each cycle it picks at most one pending request using round-robin priority.
- It drives the APB master signals through IDLE/SETUP/ACCESS, waits for PREADY and returns read data or completion to the winning requester.
- It sits between the bus-side requesters (DMA, CPU bridge, test sequencer) and the APB slave.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 32, APB address width.
- DW, 32, APB data width.
- TIMEOUT, 16, max ACCESS cycles waiting for PREADY (used only with APB_TIMEOUT_EN).

Ports:
- PCLK  in  1  clock, all logic on rising edge.
- PRESET  in  1  synchronous, active-low reset.
- req  in  NREQ  per-requester request; held high until matching gnt bit.
- req_write  in  NREQ  per-requester direction, 1=write.
- req_addr  in  NREQ*AW  flattened addresses; requester i at bits [i*AW +: AW].
- req_wdata  in  NREQ*DW  flattened write data, same packing.
- gnt  out  NREQ  one-hot, one-cycle pulse: request accepted and latched.
- rsp_valid  out  1  one-cycle pulse: transfer complete.
- rsp_id  out  $clog2(NREQ)  index of completing requester; valid with rsp_valid.
- rsp_rdata  out  DW  read data; 0 for writes; valid with rsp_valid.
- rsp_err  out  1  timeout abort flag; valid with rsp_valid.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PADDR  out  AW  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  DW  APB write data.
- PREADY  in  1  slave ready.
- PRDATA  in  DW  slave read data.

Behaviour:
- Reset (PRESET=0 at a PCLK edge) clears state and outputs regardless of state, including mid-transfer:
  - state=IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, gnt, rsp_valid, rsp_id, rsp_rdata, rsp_err all 0.
  - Round-robin pointer=0, so requester 0 has highest priority first. No rsp is issued for an aborted transfer.
- All outputs are registered; no combinational path from PREADY/PRDATA to outputs.
- IDLE:
  - PSEL=0, PENABLE=0.
  - If any req bit is set at the edge, pick winner w = first set bit searching from pointer upward, wrapping modulo NREQ.
  - Latch req_addr[w], req_wdata[w], req_write[w] into PADDR/PWDATA/PWRITE; set gnt[w]=1 for the next cycle.
  - Pointer becomes (w+1) mod NREQ; go to SETUP.
- SETUP (exactly 1 cycle):
  - PSEL=1, PENABLE=0, gnt pulse visible.
  - Next state ACCESS unconditionally.
- ACCESS:
  - PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA stable.
  - On an edge with PREADY=1: capture PRDATA (reads) or 0 (writes) into rsp_rdata; next cycle rsp_valid=1, rsp_id=w, rsp_err=0; go to IDLE with PSEL=PENABLE=0.
  - PREADY=0: stay.
- Throughput: min 3 cycles/transfer (IDLE, SETUP, ACCESS). rsp_valid coincides with the following IDLE/arbitration cycle.
- Requests:
  - A req dropped before gnt is never serviced.
  - A req still high after its gnt is treated as a new request at the next arbitration.
  - A requester must drop req in the cycle gnt is seen if it wants a single transfer.
- Fairness: with all NREQ requesting continuously, grants rotate 0,1,...,NREQ-1,0; no requester waits more than NREQ-1 transfers.
- Requester inputs are ignored outside IDLE. PREADY is ignored outside ACCESS.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT, the transfer is abandoned: next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0, state IDLE, PSEL=PENABLE=0.
  - PREADY=1 on the same edge the count hits TIMEOUT completes normally (rsp_err=0).
- Not defined: ACCESS waits indefinitely; rsp_err tied to 0; no counter logic.

Test Plan:
- Single write: req[0]=1, addr=0x04, wdata=0xDEADBEEF, PREADY=1 → gnt[0] in SETUP; ACCESS with PADDR=0x04, PWDATA=0xDEADBEEF; rsp_valid, rsp_id=0, rsp_rdata=0 next cycle.
- Read with wait states: req[2] read addr=0x04, PREADY low 3 ACCESS cycles, PRDATA=0xDEADBEEF → ACCESS lasts 4 cycles; rsp_rdata=0xDEADBEEF, rsp_id=2.
- Round-robin: all 4 req held high, PREADY=1 → grant order 0,1,2,3,0; gnt one-hot; 3 cycles between consecutive gnt pulses.
- Pointer wrap: last grant was 3, then req[1] and req[3] high → grant 1, then 3.
- Reset mid-ACCESS: PRESET=0 for 1 edge while PREADY=0 → next cycle all outputs 0, state IDLE, no rsp_valid; first grant after reset goes to lowest set index.
- APB_TIMEOUT_EN, TIMEOUT=16: PREADY held 0 → after 16 ACCESS cycles, rsp_valid=1, rsp_err=1, rsp_rdata=0, PSEL=0. Without the macro, PSEL stays high indefinitely.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// apb_master_arbiter
//   Shares one APB slave port between NREQ local requesters. A round-robin
//   arbiter picks at most one pending request per arbitration cycle. The
//   winner's address, data and direction are latched, and the transfer is run
//   through the APB SETUP and ACCESS phases. Completion is reported back on
//   rsp_*. All outputs are registered.
//
//   Optional build macro: APB_TIMEOUT_EN
//     When this macro is defined, an ACCESS phase that sees no PREADY for
//     TIMEOUT cycles is abandoned and reported with rsp_err=1. When it is not
//     defined, ACCESS waits indefinitely and rsp_err is tied to 0.
//
// Ports
//   PCLK, PRESET            clock (rising edge), synchronous active-low reset
//   req/req_write           per-requester request and direction (1 = write)
//   req_addr/req_wdata      flattened per-requester address/data, [i*W +: W]
//   gnt                     one-hot single-cycle pulse: request latched
//   rsp_valid/id/rdata/err  single-cycle completion report
//   PSEL..PWDATA            APB master outputs
//   PREADY, PRDATA          APB slave responses
// ---------------------------------------------------------------------------
module apb_master_arbiter #(
   parameter int  NREQ    = 4,
   parameter int  AW      = 32,
   parameter int  DW      = 32,
   parameter int  TIMEOUT = 16,
   localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic               PCLK,
   input  logic               PRESET,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    req_write,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]    gnt,
   output logic               rsp_valid,
   output logic [IDW-1:0]     rsp_id,
   output logic [DW-1:0]      rsp_rdata,
   output logic               rsp_err,
   output logic               PSEL,
   output logic               PENABLE,
   output logic [AW-1:0]      PADDR,
   output logic               PWRITE,
   output logic [DW-1:0]      PWDATA,
   input  logic               PREADY,
   input  logic [DW-1:0]      PRDATA
);

   if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_chk
      $error("apb_master_arbiter: NREQ must be 2..8 and TIMEOUT >= 1");
   end

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

   state_t              state_q, state_d;
   logic [IDW-1:0]      ptr_q, ptr_d;       // highest-priority requester
   logic [IDW-1:0]      owner_q, owner_d;   // requester of the transfer in flight
   logic [NREQ-1:0]     gnt_q, gnt_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]      rsp_id_q, rsp_id_d;
   logic [DW-1:0]       rsp_rdata_q, rsp_rdata_d;
   logic                psel_q, psel_d;
   logic                penable_q, penable_d;
   logic [AW-1:0]       paddr_q, paddr_d;
   logic                pwrite_q, pwrite_d;
   logic [DW-1:0]       pwdata_q, pwdata_d;

`ifdef APB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                rsp_err_q, rsp_err_d;
`endif

   // Packed per-requester views of the flattened buses.
   logic [NREQ-1:0][AW-1:0] addr_v;
   logic [NREQ-1:0][DW-1:0] wdata_v;
   assign addr_v  = req_addr;
   assign wdata_v = req_wdata;

   // Round-robin search: the first set req bit at or above ptr_q, wrapping.
   logic           found;
   logic [IDW-1:0] win;
   logic [IDW-1:0] idx;
   int             sum;
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      sum   = 0;
      for (int k = 0; k < NREQ; k++) begin
         sum = int'(ptr_q) + k;
         if (sum >= NREQ) sum = sum - NREQ;
         idx = IDW'(sum);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      gnt_d       = '0;
      rsp_valid_d = 1'b0;
      rsp_id_d    = rsp_id_q;
      rsp_rdata_d = rsp_rdata_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      paddr_d     = paddr_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
`ifdef APB_TIMEOUT_EN
      cnt_d       = cnt_q;
      rsp_err_d   = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            if (found) begin
               gnt_d[win] = 1'b1;
               paddr_d    = addr_v[win];
               pwdata_d   = wdata_v[win];
               pwrite_d   = req_write[win];
               owner_d    = win;
               ptr_d      = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
               psel_d     = 1'b1;
               state_d    = S_SETUP;
            end
         end
         S_SETUP: begin
            penable_d = 1'b1;
            state_d   = S_ACCESS;
`ifdef APB_TIMEOUT_EN
            cnt_d     = '0;
`endif
         end
         S_ACCESS: begin
            if (PREADY) begin
               rsp_valid_d = 1'b1;
               rsp_id_d    = owner_q;
               rsp_rdata_d = pwrite_q ? '0 : PRDATA;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               state_d     = S_IDLE;
            end
`ifdef APB_TIMEOUT_EN
            // This is the TIMEOUT-th stalled cycle, so abandon the transfer.
            // PREADY takes priority above, so a response on this same edge still
            // completes normally.
            else if (cnt_q == CW'(TIMEOUT - 1)) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_id_d    = owner_q;
               rsp_rdata_d = '0;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               state_d     = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (!PRESET) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         owner_q     <= '0;
         gnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_rdata_q <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
`ifdef APB_TIMEOUT_EN
         cnt_q       <= '0;
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         gnt_q       <= gnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_rdata_q <= rsp_rdata_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         paddr_q     <= paddr_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
`ifdef APB_TIMEOUT_EN
         cnt_q       <= cnt_d;
         rsp_err_q   <= rsp_err_d;
`endif
      end
   end

   assign gnt       = gnt_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_rdata = rsp_rdata_q;
   assign PSEL      = psel_q;
   assign PENABLE   = penable_q;
   assign PADDR     = paddr_q;
   assign PWRITE    = pwrite_q;
   assign PWDATA    = pwdata_q;
`ifdef APB_TIMEOUT_EN
   assign rsp_err   = rsp_err_q;
`else
   assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master_arbiter.sv
module tb_apb_master_arbiter;
   localparam int NREQ = 4, AW = 32, DW = 32, TIMEOUT = 16, IDW = 2;

   logic               PCLK = 1'b0;
   logic               PRESET;
   logic [NREQ-1:0]    req, req_write;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_wdata;
   logic [NREQ-1:0]    gnt;
   logic               rsp_valid, rsp_err;
   logic [IDW-1:0]     rsp_id;
   logic [DW-1:0]      rsp_rdata;
   logic               PSEL, PENABLE, PWRITE, PREADY;
   logic [AW-1:0]      PADDR;
   logic [DW-1:0]      PWDATA, PRDATA;

   int npass = 0, ntot = 0;

   always #5 PCLK = ~PCLK;

   apb_master_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .req(req), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
      .PREADY(PREADY), .PRDATA(PRDATA));

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
   endtask

   task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_write[i]          = wr;
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic do_reset();
      PRESET = 1'b0;
      req    = '0;
      PREADY = 1'b0;
      PRDATA = '0;
      tick();
      tick();
      PRESET = 1'b1;
   endtask

   task automatic chk_zero(input string p);
      chk({p, "_gnt"},     gnt, 0);
      chk({p, "_psel"},    PSEL, 0);
      chk({p, "_penable"}, PENABLE, 0);
      chk({p, "_pwrite"},  PWRITE, 0);
      chk({p, "_paddr"},   PADDR, 0);
      chk({p, "_pwdata"},  PWDATA, 0);
      chk({p, "_rvalid"},  rsp_valid, 0);
      chk({p, "_rid"},     rsp_id, 0);
      chk({p, "_rdata"},   rsp_rdata, 0);
      chk({p, "_rerr"},    rsp_err, 0);
   endtask

   task automatic wait_rsp(input string nm, input int exp_id);
      int n;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk({nm, "_seen"}, rsp_valid, 1);
      chk({nm, "_id"}, rsp_id, exp_id);
   endtask

   // Reference arbiter: the first requesting index at or after p, modulo NREQ.
   function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
      for (int d = 0; d < NREQ; d++)
         if (r[(p + d) % NREQ]) return (p + d) % NREQ;
      return -1;
   endfunction

   typedef struct {
      logic [NREQ-1:0] req;
      logic            pready;
      logic [DW-1:0]   prdata;
      logic [NREQ-1:0] gnt;
      logic            psel, pen;
      logic [AW-1:0]   paddr;
      logic            pwrite;
      logic [DW-1:0]   pwdata;
      logic            rv;
      logic [IDW-1:0]  id;
      logic [DW-1:0]   rdata;
   } vec_t;

   function automatic vec_t mk(input logic [3:0] rq, input logic pr, input logic [31:0] prd,
                               input logic [3:0] g, input logic ps, input logic pe,
                               input logic [31:0] pa, input logic pw, input logic [31:0] pwd,
                               input logic rv, input logic [1:0] id, input logic [31:0] rd);
      vec_t v;
      v.req = rq; v.pready = pr; v.prdata = prd; v.gnt = g; v.psel = ps; v.pen = pe;
      v.paddr = pa; v.pwrite = pw; v.pwdata = pwd; v.rv = rv; v.id = id; v.rdata = rd;
      return v;
   endfunction

   vec_t tbl[10];

   // Random-test model state
   int                 ptr_m, phase, owner, waits, w, gcnt, last_t, t, acc, seen;
   logic [NREQ-1:0]    r_req, exp_gnt;
   logic [NREQ*AW-1:0] r_addr;
   logic [NREQ*DW-1:0] r_wdata;
   logic [NREQ-1:0]    r_wr;
   logic               pr, e_wr, exp_rv, exp_err;
   logic [DW-1:0]      prd, e_wdata, exp_rdata;
   logic [AW-1:0]      e_addr;

   initial begin
      req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      PREADY = 1'b0; PRDATA = '0; PRESET = 1'b0;

      // ---- reset state
      do_reset();
      chk_zero("reset");

      // ---- table: single write by req0, then a read by req2 with 3 wait states
      tbl[0] = mk(4'b0001, 1, 32'h0,        4'b0001, 1, 0, 32'h4, 1, 32'hDEADBEEF, 0, 0, 0);
      tbl[1] = mk(4'b0000, 1, 32'h0,        4'b0000, 1, 1, 32'h4, 1, 32'hDEADBEEF, 0, 0, 0);
      tbl[2] = mk(4'b0000, 1, 32'hCAFEF00D, 4'b0000, 0, 0, 32'h0, 0, 32'h0,        1, 0, 32'h0);
      tbl[3] = mk(4'b0100, 1, 32'h0,        4'b0100, 1, 0, 32'h4, 0, 32'h11112222, 0, 0, 0);
      tbl[4] = mk(4'b0000, 1, 32'h0,        4'b0000, 1, 1, 32'h4, 0, 32'h11112222, 0, 0, 0);
      tbl[5] = mk(4'b0000, 0, 32'h55555555, 4'b0000, 1, 1, 32'h4, 0, 32'h11112222, 0, 0, 0);
      tbl[6] = mk(4'b0000, 0, 32'h55555555, 4'b0000, 1, 1, 32'h4, 0, 32'h11112222, 0, 0, 0);
      tbl[7] = mk(4'b0000, 0, 32'h55555555, 4'b0000, 1, 1, 32'h4, 0, 32'h11112222, 0, 0, 0);
      tbl[8] = mk(4'b0000, 1, 32'hDEADBEEF, 4'b0000, 0, 0, 32'h0, 0, 32'h0,        1, 2, 32'hDEADBEEF);
      tbl[9] = mk(4'b0000, 1, 32'h0,        4'b0000, 0, 0, 32'h0, 0, 32'h0,        0, 0, 0);
      set_req(0, 1, 32'h4, 32'hDEADBEEF);
      set_req(1, 0, 32'h8, 32'h0);
      set_req(2, 0, 32'h4, 32'h11112222);
      set_req(3, 0, 32'hC, 32'h0);
      for (int i = 0; i < 10; i++) begin
         req    = tbl[i].req;
         PREADY = tbl[i].pready;
         PRDATA = tbl[i].prdata;
         tick();
         chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].gnt);
         chk($sformatf("tbl%0d_psel", i), PSEL, tbl[i].psel);
         chk($sformatf("tbl%0d_penable", i), PENABLE, tbl[i].pen);
         chk($sformatf("tbl%0d_rvalid", i), rsp_valid, tbl[i].rv);
         if (tbl[i].psel) begin
            chk($sformatf("tbl%0d_paddr", i), PADDR, tbl[i].paddr);
            chk($sformatf("tbl%0d_pwrite", i), PWRITE, tbl[i].pwrite);
            chk($sformatf("tbl%0d_pwdata", i), PWDATA, tbl[i].pwdata);
         end
         if (tbl[i].rv) begin
            chk($sformatf("tbl%0d_rid", i), rsp_id, tbl[i].id);
            chk($sformatf("tbl%0d_rdata", i), rsp_rdata, tbl[i].rdata);
            chk($sformatf("tbl%0d_rerr", i), rsp_err, 0);
         end
      end

      // ---- round robin: all four held high, grants 0,1,2,3,0,1,2,3 spaced 3 cycles
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, 1, 32'h100 + i * 4, 32'hA0 + i);
      req = '1; PREADY = 1'b1;
      gcnt = 0; last_t = -1; t = 0;
      for (int c = 0; c < 40 && gcnt < 8; c++) begin
         tick();
         t++;
         if (gnt != '0) begin
            chk("rr_onehot", $onehot(gnt), 1);
            chk("rr_order", gnt, 4'b0001 << (gcnt % NREQ));
            if (last_t >= 0) chk("rr_gap", t - last_t, 3);
            last_t = t;
            gcnt++;
            if (gcnt == 8) req = '0;
         end
      end
      chk("rr_count", gcnt, 8);
      wait_rsp("rr_last_rsp", 3);

      // ---- pointer wrap: last grant was 3, now req1 and req3 -> 1 then 3
      req = 4'b1010; gcnt = 0;
      for (int c = 0; c < 20 && gcnt < 2; c++) begin
         tick();
         if (gnt != '0) begin
            chk(gcnt == 0 ? "wrap_first" : "wrap_second", gnt, gcnt == 0 ? 4'b0010 : 4'b1000);
            req = req & ~gnt;
            gcnt++;
         end
      end
      chk("wrap_count", gcnt, 2);
      wait_rsp("wrap_rsp", 3);

      // ---- reset in the middle of ACCESS
      set_req(2, 0, 32'h40, 32'h0);
      req = 4'b0100; PREADY = 1'b0;
      tick();
      chk("mr_gnt", gnt, 4'b0100);
      req = '0;
      tick();
      chk("mr_access", {PSEL, PENABLE}, 2'b11);
      PRESET = 1'b0;
      tick();
      PRESET = 1'b1;
      chk_zero("mr");
      set_req(1, 1, 32'h24, 32'h77);
      set_req(3, 1, 32'h2C, 32'h99);
      req = 4'b1010; PREADY = 1'b1;
      tick();
      chk("mr_first_gnt", gnt, 4'b0010);
      chk("mr_no_rsp", rsp_valid, 0);
      req = '0;
      wait_rsp("mr_rsp", 1);
      chk("mr_rsp_rdata", rsp_rdata, 0);

      // ---- stalled slave: timeout abort, or an indefinite wait without the feature
      do_reset();
      set_req(0, 0, 32'h8, 32'h0);
      req = 4'b0001; PREADY = 1'b0;
      tick();
      chk("to_gnt", gnt, 4'b0001);
      req = '0;
      acc = 0; seen = 0;
      for (int c = 0; c < 60; c++) begin
         tick();
         if (rsp_valid === 1'b1) begin
            seen = 1;
            break;
         end
         if (PSEL && PENABLE) acc++;
      end
`ifdef APB_TIMEOUT_EN
      chk("to_access_cycles", acc, TIMEOUT);
      chk("to_rsp_seen", seen, 1);
      chk("to_rsp_err", rsp_err, 1);
      chk("to_rsp_rdata", rsp_rdata, 0);
      chk("to_rsp_id", rsp_id, 0);
      chk("to_psel", {PSEL, PENABLE}, 2'b00);
`else
      chk("hang_access_cycles", acc, 60);
      chk("hang_no_rsp", seen, 0);
      chk("hang_psel", PSEL, 1);
`endif

      // ---- PREADY on the TIMEOUT-th ACCESS edge completes normally
      do_reset();
      set_req(0, 0, 32'h8, 32'h0);
      req = 4'b0001; PREADY = 1'b0;
      tick();
      req = '0;
      tick();
      repeat (TIMEOUT - 1) tick();
      chk("edge_still_access", {PSEL, PENABLE}, 2'b11);
      PREADY = 1'b1; PRDATA = 32'h13579BDF;
      tick();
      chk("edge_rsp_valid", rsp_valid, 1);
      chk("edge_rsp_err", rsp_err, 0);
      chk("edge_rsp_rdata", rsp_rdata, 32'h13579BDF);

      // ---- randomized traffic against the reference model
      do_reset();
      ptr_m = 0; phase = 0; owner = 0; waits = 0;
      e_addr = '0; e_wr = 1'b0; e_wdata = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req[i]) begin
               if ($urandom_range(0, 2) == 0) begin
                  req[i] = 1'b1;
                  set_req(i, 1'($urandom_range(0, 1)), $urandom(), $urandom());
               end
            end else if ($urandom_range(0, 29) == 0) begin
               req[i] = 1'b0;
            end
         end
         PREADY = ($urandom_range(0, 9) < 5);
         PRDATA = $urandom();
         r_req = req; r_addr = req_addr; r_wdata = req_wdata; r_wr = req_write;
         pr = PREADY; prd = PRDATA;
         tick();

         exp_gnt = '0; exp_rv = 1'b0; exp_err = 1'b0; exp_rdata = '0;
         case (phase)
            0: if (r_req != '0) begin
                  w = rr_pick(r_req, ptr_m);
                  exp_gnt[w] = 1'b1;
                  ptr_m   = (w + 1) % NREQ;
                  owner   = w;
                  e_addr  = r_addr[w*AW +: AW];
                  e_wdata = r_wdata[w*DW +: DW];
                  e_wr    = r_wr[w];
                  phase   = 1;
               end
            1: begin
                  phase = 2;
                  waits = 0;
               end
            default: begin
                  if (pr) begin
                     exp_rv = 1'b1;
                     exp_rdata = e_wr ? '0 : prd;
                     phase = 0;
                  end else begin
                     waits++;
`ifdef APB_TIMEOUT_EN
                     if (waits == TIMEOUT) begin
                        exp_rv = 1'b1;
                        exp_err = 1'b1;
                        phase = 0;
                     end
`endif
                  end
               end
         endcase

         chk("rnd_gnt", gnt, exp_gnt);
         chk("rnd_psel", PSEL, phase != 0);
         chk("rnd_penable", PENABLE, phase == 2);
         chk("rnd_rvalid", rsp_valid, exp_rv);
         if (phase != 0) begin
            chk("rnd_paddr", PADDR, e_addr);
            chk("rnd_pwrite", PWRITE, e_wr);
            chk("rnd_pwdata", PWDATA, e_wdata);
         end
         if (exp_rv) begin
            chk("rnd_rid", rsp_id, owner);
            chk("rnd_rdata", rsp_rdata, exp_rdata);
            chk("rnd_rerr", rsp_err, exp_err);
         end

         // Granted requesters mostly drop, sometimes keep going with a new transfer.
         for (int i = 0; i < NREQ; i++) begin
            if (exp_gnt[i]) begin
               if ($urandom_range(0, 3) == 0)
                  set_req(i, 1'($urandom_range(0, 1)), $urandom(), $urandom());
               else
                  req[i] = 1'b0;
            end
         end
      end

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
